// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port B arbiter: FSM encoding, defaults and
// packing widths for the flattened requester address/data buses.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 16;

    // Lowest address peripherals may write when write protection is built in.
    localparam logic [15:0] DEF_PROG_LIMIT = 16'h0100;

    // Requester i occupies bits [i*W +: W] of the packed buses.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/bram_portb_arbiter_if.sv
// Requester-side bus of the port B arbiter: per-requester request lines,
// packed address/data, and the one-hot grant/read-valid returns.
interface bram_portb_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      wr_err;

    // Requesters side.
    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata, wr_err
    );

    // Arbiter side.
    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata, wr_err
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request bit searching upward from last_gnt+1,
// wrapping modulo NUM_REQ.
module rr_priority_pick #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] onehot_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    int unsigned cand;

    // Scan NUM_REQ positions after the previous winner; first hit wins.
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_gnt) + k) % NUM_REQ;
            if (!any_c && req[IDX_W'(cand)]) begin
                any_c                   = 1'b1;
                idx_c                   = IDX_W'(cand);
                onehot_c[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter owning BRAM port B; serialises single-word reads and
// writes from NUM_REQ peripherals. Optional write protection of the program
// region below PROG_LIMIT is enabled by defining BRAM_PORTB_WPROT_EN.
module bram_portb_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
`ifdef BRAM_PORTB_WPROT_EN
    ,
    parameter logic [ADDR_W-1:0] PROG_LIMIT = ADDR_W'(DEF_PROG_LIMIT)
`endif
) (
    input  logic               clk,
    input  logic               reset,
    bram_portb_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]  addr_b,
    output logic [DATA_W-1:0]  data_b,
    output logic               we_b,
    input  logic [DATA_W-1:0]  q_b
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic               wr_q, wr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               wr_err_q, wr_err_d;
    logic [ADDR_W-1:0]  addr_b_q, addr_b_d;
    logic [DATA_W-1:0]  data_b_q, data_b_d;
    logic               we_b_q, we_b_d;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] pick_onehot_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_any_c;

    // Unpack the flattened requester buses into per-requester words.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[slice_lsb(i, ADDR_W) +: ADDR_W];
        assign wdata_arr[i] = bus.req_wdata[slice_lsb(i, DATA_W) +: DATA_W];
    end

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (bus.req),
        .last_gnt (last_gnt_q),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        wr_err_d   = 1'b0;
        addr_b_d   = addr_b_q;
        data_b_d   = data_b_q;
        we_b_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any_c) begin
                    addr_b_d   = addr_arr[pick_idx_c];
                    data_b_d   = wdata_arr[pick_idx_c];
                    we_b_d     = bus.req_we[pick_idx_c];
                    wr_d       = bus.req_we[pick_idx_c];
                    gnt_d      = pick_onehot_c;
                    last_gnt_d = pick_idx_c;
                    state_d    = ISSUE;
`ifdef BRAM_PORTB_WPROT_EN
                    if (bus.req_we[pick_idx_c] && (addr_arr[pick_idx_c] < PROG_LIMIT)) begin
                        we_b_d   = 1'b0;
                        wr_err_d = 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = wr_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rdata_d  = q_b;
                rvalid_d = NUM_REQ'(1) << last_gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            wr_q       <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            wr_err_q   <= 1'b0;
            addr_b_q   <= '0;
            data_b_q   <= '0;
            we_b_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            wr_err_q   <= wr_err_d;
            addr_b_q   <= addr_b_d;
            data_b_q   <= data_b_d;
            we_b_q     <= we_b_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.wr_err = wr_err_q;
    assign addr_b     = addr_b_q;
    assign data_b     = data_b_q;
    assign we_b       = we_b_q;

endmodule
